// File: rtl/min_max_finder_param.sv
// min_max_finder_param: W x N array loaded while idle, scanned once for first max/min (signed or unsigned)
module min_max_finder_param #(
    parameter int W = 8,
    parameter int N = 16,
    localparam int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Wr_en,
    input  logic [AW-1:0] Wr_addr,
    input  logic [W-1:0]  Wr_data,
    input  logic          Start,
    input  logic          Signed_mode,
    input  logic          Ack,
    output logic [W-1:0]  Max,
    output logic [W-1:0]  Min,
    output logic [AW-1:0] Max_idx,
    output logic [AW-1:0] Min_idx,
    output logic          Qi,
    output logic          Ql,
    output logic          Qc,
    output logic          Qd
);
    typedef enum logic [3:0] {INI = 4'b0001, LOAD = 4'b0010, CMP = 4'b0100, DONE = 4'b1000} state_t;
    state_t        state_q, state_d;
    logic [W-1:0]  mem_q [N];
    logic [W-1:0]  max_q, max_d, min_q, min_d, cur;
    logic [AW-1:0] max_idx_q, max_idx_d, min_idx_q, min_idx_d, i_q, i_d;
    logic          mode_q, mode_d, gt, lt;
    // array write port, open only while idle; contents are not reset so they survive an abort
    always_ff @(posedge Clk)
        if (state_q == INI && Wr_en && 32'(Wr_addr) < N) mem_q[Wr_addr] <= Wr_data;
    // next state: LOAD seeds the extremes from M[0], CMP folds in M[I] with strict compares
    always_comb begin
        cur       = mem_q[i_q];
        gt        = mode_q ? ($signed(cur) > $signed(max_q)) : (cur > max_q);
        lt        = mode_q ? ($signed(cur) < $signed(min_q)) : (cur < min_q);
        state_d   = state_q;
        max_d     = max_q;
        min_d     = min_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;
        i_d       = i_q;
        mode_d    = mode_q;
        case (state_q)
            INI: begin
                mode_d  = Start ? Signed_mode : mode_q;
                state_d = Start ? LOAD : INI;
            end
            LOAD: begin
                max_d     = mem_q[0];
                min_d     = mem_q[0];
                max_idx_d = '0;
                min_idx_d = '0;
                i_d       = AW'(1);
                state_d   = (N == 1) ? DONE : CMP;
            end
            CMP: begin
                max_d     = gt ? cur : max_q;
                max_idx_d = gt ? i_q : max_idx_q;
                min_d     = lt ? cur : min_q;
                min_idx_d = lt ? i_q : min_idx_q;
                i_d       = i_q + 1'b1;
                state_d   = (i_q == AW'(N - 1)) ? DONE : CMP;
            end
            DONE: state_d = Ack ? INI : DONE;
            default: state_d = INI;
        endcase
    end
    // state and result registers; an active-low reset aborts any scan and clears results
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= INI;
            max_q     <= '0;
            min_q     <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
            i_q       <= '0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            max_q     <= max_d;
            min_q     <= min_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
            i_q       <= i_d;
            mode_q    <= mode_d;
        end
    end
    assign Max     = max_q;
    assign Min     = min_q;
    assign Max_idx = max_idx_q;
    assign Min_idx = min_idx_q;
    assign {Qd, Qc, Ql, Qi} = state_q;
endmodule
